// File: rtl/cp0_timer.sv
// cp0_timer: MIPS coprocessor-0 with SR, Cause, EPC, PRID and an optional
// Count/Compare timer. External interrupt line i lands on Cause.IP bit 10+i.
// When the timer is present it owns IP bit 15, so external line 5 is ignored.
module cp0_timer #(
   parameter int unsigned HWINT_W   = 6,
   parameter int unsigned TIMER_EN  = 1,
   parameter int unsigned COUNT_DIV = 1,
   parameter logic [31:0] PRID_VAL  = 32'h0000_0000,
   parameter logic [29:0] EPC_INIT  = 30'h0000_0C00
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [29:0]        PC,
   input  logic [31:0]        Din,
   input  logic [HWINT_W-1:0] HWInt,
   input  logic [4:0]         Sel,
   input  logic               Wen,
   input  logic               EXLSet,
   input  logic [4:0]         ExcCode,
   input  logic               EXLClr,
   output logic               IntReq,
   output logic [29:0]        EPC,
   output logic [31:0]        DOut
);

   localparam logic [4:0] SEL_COUNT   = 5'd9;
   localparam logic [4:0] SEL_COMPARE = 5'd11;
   localparam logic [4:0] SEL_SR      = 5'd12;
   localparam logic [4:0] SEL_CAUSE   = 5'd13;
   localparam logic [4:0] SEL_EPC     = 5'd14;
   localparam logic [4:0] SEL_PRID    = 5'd15;

   localparam logic                TIMER_ON   = (TIMER_EN != 0);
   localparam int unsigned         PRESC_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(COUNT_DIV - 1);
   // Timer owns IP bit 15 when present; otherwise all six external lines pass.
   localparam logic [5:0]          HW_MASK    = TIMER_ON ? 6'b01_1111 : 6'b11_1111;

   // Architectural state
   logic [5:0]         ip_ext_r;
   logic [5:0]         im_r;
   logic               exl_r;
   logic               ie_r;
   logic [4:0]         exc_code_r;
   logic [29:0]        epc_r;
   logic [31:0]        count_r;
   logic [31:0]        compare_r;
   logic [PRESC_W-1:0] presc_r;
   logic               ti_r;

   // Combinational helpers
   logic               wr_count_s;
   logic               wr_compare_s;
   logic               wr_sr_s;
   logic               wr_epc_s;
   logic               tick_s;
   logic [31:0]        count_next_s;
   logic               match_s;
   logic [5:0]         hw_masked_s;
   logic [5:0]         ip_all_s;
   logic [31:0]        sr_s;
   logic [31:0]        cause_s;

   // Decode mtc0 targets and the prescaler tick.
   always_comb begin
      wr_count_s   = 1'b0;
      wr_compare_s = 1'b0;
      wr_sr_s      = 1'b0;
      wr_epc_s     = 1'b0;
      if (Wen) begin
         wr_count_s   = (Sel == SEL_COUNT);
         wr_compare_s = (Sel == SEL_COMPARE);
         wr_sr_s      = (Sel == SEL_SR);
         wr_epc_s     = (Sel == SEL_EPC);
      end else begin
         wr_count_s   = 1'b0;
         wr_compare_s = 1'b0;
         wr_sr_s      = 1'b0;
         wr_epc_s     = 1'b0;
      end
      tick_s       = TIMER_ON && (presc_r == PRESC_LAST);
      count_next_s = count_r + 32'd1;
      // A Count write suppresses the increment, so it also suppresses a match.
      match_s      = tick_s && !wr_count_s && (count_next_s == compare_r);
   end

   // Zero-extend the external lines to six IP positions and drop any line the timer owns.
   always_comb begin
      hw_masked_s = 6'(HWInt) & HW_MASK;
   end

   // Prescaler: counts 0..COUNT_DIV-1; restarts on reset or a Count write.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_r <= '0;
      end else if (!TIMER_ON) begin
         presc_r <= '0;
      end else if (wr_count_s || tick_s) begin
         presc_r <= '0;
      end else begin
         presc_r <= presc_r + PRESC_W'(1);
      end
   end

   // Count register: software load has priority over the tick increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= 32'h0000_0000;
      end else if (!TIMER_ON) begin
         count_r <= 32'h0000_0000;
      end else if (wr_count_s) begin
         count_r <= Din;
      end else if (tick_s) begin
         count_r <= count_next_s;
      end else begin
         count_r <= count_r;
      end
   end

   // Compare register.
   always_ff @(posedge clk) begin
      if (reset) begin
         compare_r <= 32'hFFFF_FFFF;
      end else if (!TIMER_ON) begin
         compare_r <= 32'hFFFF_FFFF;
      end else if (wr_compare_s) begin
         compare_r <= Din;
      end else begin
         compare_r <= compare_r;
      end
   end

   // Timer latch: a Compare write clears it even when a match occurs on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         ti_r <= 1'b0;
      end else if (!TIMER_ON) begin
         ti_r <= 1'b0;
      end else if (wr_compare_s) begin
         ti_r <= 1'b0;
      end else if (match_s) begin
         ti_r <= 1'b1;
      end else begin
         ti_r <= ti_r;
      end
   end

   // External IP bits: one-cycle registered sample of the interrupt lines.
   always_ff @(posedge clk) begin
      if (reset) begin
         ip_ext_r <= 6'b00_0000;
      end else begin
         ip_ext_r <= hw_masked_s;
      end
   end

   // SR.IM and SR.IE: written only by mtc0.
   always_ff @(posedge clk) begin
      if (reset) begin
         im_r <= 6'b00_0000;
         ie_r <= 1'b1;
      end else if (wr_sr_s) begin
         im_r <= Din[15:10];
         ie_r <= Din[0];
      end else begin
         im_r <= im_r;
         ie_r <= ie_r;
      end
   end

   // SR.EXL: exception entry beats eret, and both beat a software write.
   always_ff @(posedge clk) begin
      if (reset) begin
         exl_r <= 1'b0;
      end else if (EXLSet) begin
         exl_r <= 1'b1;
      end else if (EXLClr) begin
         exl_r <= 1'b0;
      end else if (wr_sr_s) begin
         exl_r <= Din[1];
      end else begin
         exl_r <= exl_r;
      end
   end

   // EPC: exception entry captures the PC in preference to a software write.
   always_ff @(posedge clk) begin
      if (reset) begin
         epc_r <= EPC_INIT;
      end else if (EXLSet) begin
         epc_r <= PC;
      end else if (wr_epc_s) begin
         epc_r <= Din[31:2];
      end else begin
         epc_r <= epc_r;
      end
   end

   // Cause.ExcCode: captured on exception entry only; Cause is read-only to software.
   always_ff @(posedge clk) begin
      if (reset) begin
         exc_code_r <= 5'd0;
      end else if (EXLSet) begin
         exc_code_r <= ExcCode;
      end else begin
         exc_code_r <= exc_code_r;
      end
   end

   // Assemble the visible SR and Cause words and the interrupt request.
   always_comb begin
      ip_all_s = ip_ext_r | {ti_r, 5'b0_0000};
      sr_s     = {16'h0000, im_r, 8'h00, exl_r, ie_r};
      cause_s  = {1'b0, ti_r, 14'h0000, ip_all_s, 3'b000, exc_code_r, 2'b00};
      IntReq   = (|(ip_all_s & im_r)) & ie_r & ~exl_r;
      EPC      = epc_r;
   end

   // mfc0 read mux; unmapped selects read zero.
   always_comb begin
      DOut = 32'h0000_0000;
      case (Sel)
         SEL_COUNT:   DOut = count_r;
         SEL_COMPARE: DOut = TIMER_ON ? compare_r : 32'h0000_0000;
         SEL_SR:      DOut = sr_s;
         SEL_CAUSE:   DOut = cause_s;
         SEL_EPC:     DOut = {epc_r, 2'b00};
         SEL_PRID:    DOut = PRID_VAL;
         default:     DOut = 32'h0000_0000;
      endcase
   end

endmodule

// File: tb/tb_cp0_timer.sv
// Directed bench for cp0_timer. Two instances share every input: u_a uses
// COUNT_DIV=2 and u_b uses COUNT_DIV=1, so both prescaler settings are covered.
module tb_cp0_timer;

   localparam logic [31:0] PRID = 32'h0001_8001;

   logic        clk;
   logic        reset;
   logic [29:0] PC;
   logic [31:0] Din;
   logic [4:0]  HWInt;
   logic [4:0]  Sel;
   logic        Wen;
   logic        EXLSet;
   logic [4:0]  ExcCode;
   logic        EXLClr;

   logic        intreq_a, intreq_b;
   logic [29:0] epc_a, epc_b;
   logic [31:0] dout_a, dout_b;

   int checks = 0;
   int errors = 0;

   cp0_timer #(.HWINT_W(5), .TIMER_EN(1), .COUNT_DIV(2), .PRID_VAL(PRID),
               .EPC_INIT(30'h0000_0C00)) u_a (
      .clk(clk), .reset(reset), .PC(PC), .Din(Din), .HWInt(HWInt), .Sel(Sel),
      .Wen(Wen), .EXLSet(EXLSet), .ExcCode(ExcCode), .EXLClr(EXLClr),
      .IntReq(intreq_a), .EPC(epc_a), .DOut(dout_a));

   cp0_timer #(.HWINT_W(5), .TIMER_EN(1), .COUNT_DIV(1), .PRID_VAL(PRID),
               .EPC_INIT(30'h0000_0C00)) u_b (
      .clk(clk), .reset(reset), .PC(PC), .Din(Din), .HWInt(HWInt), .Sel(Sel),
      .Wen(Wen), .EXLSet(EXLSet), .ExcCode(ExcCode), .EXLClr(EXLClr),
      .IntReq(intreq_b), .EPC(epc_b), .DOut(dout_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Select a register and let the read mux settle.
   task automatic rd(input logic [4:0] s);
      Sel = s;
      #1;
   endtask

   // mtc0 for one cycle.
   task automatic wr(input logic [4:0] s, input logic [31:0] d);
      Sel = s; Din = d; Wen = 1'b1;
      step();
      Wen = 1'b0; Din = 32'h0;
   endtask

   initial begin
      reset = 1'b1; PC = 30'h0; Din = 32'h0; HWInt = 5'b0; Sel = 5'd12;
      Wen = 1'b0; EXLSet = 1'b0; ExcCode = 5'd0; EXLClr = 1'b0;

      // Reset state
      step();
      rd(5'd12); chk("rst_sr", dout_a, 32'h0000_0001);
      rd(5'd13); chk("rst_cause", dout_a, 32'h0000_0000);
      rd(5'd14); chk("rst_epc", dout_a, 32'h0000_3000);
      rd(5'd15); chk("rst_prid", dout_a, PRID);
      rd(5'd9);  chk("rst_count", dout_a, 32'h0000_0000);
      rd(5'd11); chk("rst_compare", dout_a, 32'hFFFF_FFFF);
      chk("rst_intreq", {31'b0, intreq_a}, 32'h0);
      reset = 1'b0;

      // IP sampling and EXL masking
      wr(5'd12, 32'h0000_5001);
      rd(5'd12); chk("sr_wr", dout_a, 32'h0000_5001);
      HWInt = 5'b00101;
      chk("hw_pre_edge", {31'b0, intreq_a}, 32'h0);
      step();
      rd(5'd13); chk("ip_cause", dout_a, 32'h0000_1400);
      chk("ip_intreq", {31'b0, intreq_a}, 32'h1);
      EXLSet = 1'b1; PC = 30'h1234_5678; ExcCode = 5'd0;
      step();
      EXLSet = 1'b0;
      chk("exl_intreq", {31'b0, intreq_a}, 32'h0);
      chk("exl_epc", {2'b0, epc_a}, 32'h1234_5678);
      rd(5'd12); chk("exl_sr", dout_a, 32'h0000_5003);
      EXLClr = 1'b1;
      step();
      EXLClr = 1'b0;
      chk("eret_intreq", {31'b0, intreq_a}, 32'h1);
      HWInt = 5'b0;
      step();
      chk("hw_low_intreq", {31'b0, intreq_a}, 32'h0);
      rd(5'd13); chk("hw_low_cause", dout_a, 32'h0000_0000);

      // Simultaneous events
      EXLSet = 1'b1; EXLClr = 1'b1; PC = 30'h0000_0200;
      step();
      EXLSet = 1'b0; EXLClr = 1'b0;
      rd(5'd12); chk("set_clr_exl", dout_a, 32'h0000_5003);
      EXLClr = 1'b1; step(); EXLClr = 1'b0;
      wr(5'd14, 32'hAAAA_AAA8);
      chk("epc_wr", {2'b0, epc_a}, 32'h2AAA_AAAA);
      rd(5'd14); chk("epc_rd", dout_a, 32'hAAAA_AAA8);
      EXLSet = 1'b1; PC = 30'h0000_0100;
      Sel = 5'd14; Din = 32'hAAAA_AAA8; Wen = 1'b1;
      step();
      Wen = 1'b0; EXLSet = 1'b0;
      chk("epc_set_wins", {2'b0, epc_a}, 32'h0000_0100);
      EXLSet = 1'b1; Sel = 5'd12; Din = 32'h0000_8001; Wen = 1'b1;
      step();
      Wen = 1'b0; EXLSet = 1'b0;
      rd(5'd12); chk("sr_wr_exlset", dout_a, 32'h0000_8003);

      // Timer, COUNT_DIV=2 on u_a
      wr(5'd12, 32'h0000_8001);
      rd(5'd12); chk("sr_timer", dout_a, 32'h0000_8001);
      wr(5'd11, 32'h0000_0008);
      wr(5'd9, 32'h0000_0005);
      rd(5'd9); chk("cnt_load", dout_a, 32'h0000_0005);
      repeat (5) step();
      chk("cnt_5clk", dout_a, 32'h0000_0007);
      chk("cnt_5clk_intreq", {31'b0, intreq_a}, 32'h0);
      step();
      chk("cnt_6clk", dout_a, 32'h0000_0008);
      rd(5'd13); chk("timer_cause", dout_a, 32'h4000_8000);
      chk("timer_intreq", {31'b0, intreq_a}, 32'h1);
      repeat (2) step();
      chk("timer_hold", {31'b0, intreq_a}, 32'h1);
      EXLSet = 1'b1; ExcCode = 5'd0; step(); EXLSet = 1'b0;
      chk("timer_exl_mask", {31'b0, intreq_a}, 32'h0);
      chk("timer_exl_keep", dout_a, 32'h4000_8000);
      EXLClr = 1'b1; step(); EXLClr = 1'b0;
      chk("timer_eret", {31'b0, intreq_a}, 32'h1);
      wr(5'd11, 32'h0000_0100);
      rd(5'd13); chk("cmp_clr_cause", dout_a, 32'h0000_0000);
      chk("cmp_clr_intreq", {31'b0, intreq_a}, 32'h0);

      // Wrap, COUNT_DIV=1 on u_b
      wr(5'd11, 32'h0000_0000);
      wr(5'd9, 32'hFFFF_FFFF);
      rd(5'd9); chk("wrap_load", dout_b, 32'hFFFF_FFFF);
      rd(5'd13); chk("wrap_pre_ti", dout_b, 32'h0000_0000);
      step();
      rd(5'd9); chk("wrap_count", dout_b, 32'h0000_0000);
      chk("div2_no_tick", dout_a, 32'hFFFF_FFFF);
      rd(5'd13); chk("wrap_ti", dout_b, 32'h4000_8000);
      chk("wrap_intreq", {31'b0, intreq_b}, 32'h1);
      wr(5'd9, 32'hFFFF_FFFF);
      wr(5'd11, 32'h0000_0000);
      rd(5'd9); chk("coinc_count", dout_b, 32'h0000_0000);
      rd(5'd13); chk("coinc_ti", dout_b, 32'h0000_0000);
      chk("coinc_intreq", {31'b0, intreq_b}, 32'h0);

      // Exception code, read-only Cause, unmapped select
      EXLSet = 1'b1; ExcCode = 5'd12; step(); EXLSet = 1'b0; ExcCode = 5'd0;
      rd(5'd13); chk("exccode_b", dout_b, 32'h0000_0030);
      chk("exccode_a", {27'b0, dout_a[6:2]}, 32'd12);
      wr(5'd13, 32'hFFFF_FFFF);
      rd(5'd13); chk("cause_ro", dout_b, 32'h0000_0030);
      rd(5'd3);  chk("sel_unmapped", dout_b, 32'h0000_0000);

      // Reset mid-count
      reset = 1'b1; step(); reset = 1'b0;
      rd(5'd9);  chk("mid_rst_cnt", dout_b, 32'h0000_0000);
      rd(5'd12); chk("mid_rst_sr", dout_b, 32'h0000_0001);
      step();
      rd(5'd9);  chk("post_rst_b1", dout_b, 32'h0000_0001);
      chk("post_rst_a1", dout_a, 32'h0000_0000);
      step();
      chk("post_rst_a2", dout_a, 32'h0000_0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cp0_timer.md
# cp0_timer

Parametrised coprocessor-0 for the MIPS core: the successor to the fixed six-line CP0. It holds SR, Cause, EPC and PRID, plus a free-running Count/Compare timer that raises an internal timer interrupt. It records a synchronous exception code on exception entry and drives IntReq to the pipeline's exception/interrupt controller. The width of the external interrupt vector, the timer mode and the identification values are all parameters.

## Interface
- HWINT_W, 6: number of external interrupt lines (1..6); line i maps to Cause.IP/SR.IM bit 10+i. Must be ≤5 when TIMER_EN=1.
- TIMER_EN, 1: 1 = Count/Compare present and timer interrupt on bit 15; 0 = Count/Compare read 0, writes ignored.
- COUNT_DIV, 1: Count increments once every COUNT_DIV clocks (≥1).
- PRID_VAL, 32'h0000_0000: constant PRID value.
- EPC_INIT, 30'h0000_0C00: EPC[31:2] reset value.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- PC  in  30  PC[31:2] of the faulting/interrupted instruction.
- Din  in  32  write data for mtc0.
- HWInt  in  HWINT_W  level-sensitive external interrupt lines.
- Sel  in  5  register select: 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PRID.
- Wen  in  1  write enable (mtc0).
- EXLSet  in  1  exception/interrupt entry.
- ExcCode  in  5  cause code captured on EXLSet (0 = interrupt).
- EXLClr  in  1  eret.
- IntReq  out  1  interrupt request.
- EPC  out  30  current EPC[31:2].
- DOut  out  32  read data for mfc0.

## Operation
- SR layout: IM[15:10], EXL bit 1, IE bit 0; all other bits read 0. Reset value: SR=32'h0000_0001 (IE=1, EXL=0, IM=0).
- Cause layout: TI bit 30, IP[15:10], ExcCode[6:2]; all other bits 0. Reset value 0. Cause is read-only; Wen to Sel 13 is ignored.
- External IP bits: IP[10+i] <= HWInt[i] every clock, i.e. a registered one-cycle sample.
- Timer IP: bit 15 and TI both reflect the timer latch.
- IntReq = |(IP & IM) & IE & ~EXL. It is combinational from registered state only.
- EXLSet: EXL<=1, EPC<=PC, ExcCode<=ExcCode input.
- EXLClr: EXL<=0.
- EXLSet and EXLClr in the same cycle: EXLSet wins.
- Wen to SR: writes IM, EXL and IE from Din. If EXLSet or EXLClr is active in the same cycle, the hardware event overrides the EXL bit only.
- Wen to EPC: EPC<=Din[31:2]. EXLSet in the same cycle wins.
- Count:
  - A prescaler ticks every COUNT_DIV clocks. On a tick, Count <= Count+1, wrapping from 32'hFFFF_FFFF to 0.
  - Wen to Count loads Din, restarts the prescaler and suppresses that cycle's increment.
- Timer latch:
  - Set on the edge where a tick makes Count+1 equal Compare.
  - Cleared by any Wen to Compare. A Compare write in the same cycle as a match clears the latch; the match uses the old Compare value.
  - Not cleared by EXLSet or EXLClr.
- Reset values: Count=0, Compare=32'hFFFF_FFFF, latch=0, prescaler=0.
- DOut is a combinational mux on Sel. EPC reads as {EPC,2'b00}. Unlisted Sel values read 32'h0.
- Reset dominates every other input.

## Timing
- Write-to-read latency: a write issued at edge N is visible on DOut after edge N. Same-cycle reads return the old value.
- HWInt to IntReq: 1 clock.
- Count==Compare match to IntReq: asserted after the matching edge, provided IM7, IE and ~EXL all hold.
- EXLSet deasserts IntReq after the edge on which it is sampled.
- Reset applied mid-count: Count and the prescaler return to 0 on that edge.

## Test plan
- Reset: hold reset 1 clk with Sel=12, 13 and 14 → DOut=32'h0000_0001, 32'h0, {EPC_INIT,2'b0}; Sel=15 → PRID_VAL.
- IP sampling: SR write 32'h0000_5001 (IM bits 12 and 14, IE), then HWInt=6'b000101 (lines 0 and 2, IP bits 10 and 12) → Cause=32'h0000_1400 and IntReq=1 after 1 clk; then EXLSet with PC=30'h1234_5678 and ExcCode=0 → IntReq=0, EPC=30'h1234_5678; then EXLClr → IntReq=1.
- Simultaneous events: EXLSet+EXLClr → EXL=1. Wen EPC=32'hAAAA_AAA8 with EXLSet PC=30'h0000_0100 → EPC=30'h0000_0100. Wen SR with Din[1]=0 and EXLSet → EXL=1.
- Timer (COUNT_DIV=2, TIMER_EN=1): write Count=5, Compare=8 → Count reaches 8 after 6 clks, then Cause=32'h4000_8000. With SR=32'h0000_8001, IntReq=1. A write to Compare clears TI and IntReq.
- Wrap: write Count=32'hFFFF_FFFF and Compare=0 (COUNT_DIV=1) → next clk Count=0 and TI=1. Compare write coincident with the match → TI=0.
- Exception code: EXLSet with ExcCode=5'd12 → Cause[6:2]=12. Writes to Cause are ignored. Sel=3 → DOut=0.
